// File: rtl/ysyx_22041071_axi_rd_arb_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_axi_rd_arb_pkg
// Shared constants for the two-port AXI read arbiter: bus widths, port
// numbering, AXI IDs per port and the arbiter FSM state encoding.
// ---------------------------------------------------------------------------
package ysyx_22041071_axi_rd_arb_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 8;
  localparam int SIZE_W = 2;
  localparam int RESP_W = 2;
  localparam int ID_W   = 4;

  // Port numbering, also used as the last-grant encoding in the arbiter.
  localparam logic PORT_IFU = 1'b0;
  localparam logic PORT_LSU = 1'b1;

  localparam logic [ID_W-1:0] ID_IFU = 4'd0;
  localparam logic [ID_W-1:0] ID_LSU = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  function automatic logic [ID_W-1:0] port_to_id(input logic port);
    return (port == PORT_LSU) ? ID_LSU : ID_IFU;
  endfunction

endpackage

// File: rtl/ysyx_22041071_rr_arb2.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_rr_arb2
// Two-way round-robin grant logic. A lone requester always wins; on a tie
// the port that was not granted last wins. The last-grant register resets
// to port 1 so the first tie after reset goes to port 0.
//
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   req_i[1:0]  request per port
//   upd_i       grant is being consumed this cycle; record it as last grant
//   gnt_o[1:0]  one-hot grant (combinational), 0 when no request
// ---------------------------------------------------------------------------
module ysyx_22041071_rr_arb2
  import ysyx_22041071_axi_rd_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o  = req_i;
    last_d = last_q;
    if (req_i == 2'b11) begin
      gnt_o = (last_q == PORT_LSU) ? 2'b01 : 2'b10;
    end
    if (upd_i && (gnt_o != 2'b00)) begin
      last_d = gnt_o[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= PORT_LSU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ysyx_22041071_axi_rd_arb.sv
// ---------------------------------------------------------------------------
// ysyx_22041071_axi_rd_arb
// Arbitrates read requests from the fetch unit (port 0) and the load unit
// (port 1) onto a single AXI read master. One transaction is in flight at a
// time: IDLE grants and latches a request, ISSUE presents it to the master,
// WAIT routes response beats back to the granted port combinationally and
// checks the beat count against the latched burst length.
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   ifu_ar_valid/ready, ifu_addr/len/size   fetch request (port 0)
//   lsu_ar_valid/ready, lsu_addr/len/size   load request (port 1)
//   ifu_r_valid/data/resp/last          fetch response beat
//   lsu_r_valid/data/resp/last          load response beat
//   cpu_ar_valid/ready, cpu_id/addr/len/size  request to the read master
//   cpu_r_valid/data/resp/last          beat from the read master
//   arb_err                             sticky beat-count protocol error
// ---------------------------------------------------------------------------
module ysyx_22041071_axi_rd_arb
  import ysyx_22041071_axi_rd_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,

  input  logic              ifu_ar_valid,
  output logic              ifu_ar_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  input  logic [LEN_W-1:0]  ifu_len,
  input  logic [SIZE_W-1:0] ifu_size,

  input  logic              lsu_ar_valid,
  output logic              lsu_ar_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [LEN_W-1:0]  lsu_len,
  input  logic [SIZE_W-1:0] lsu_size,

  output logic              ifu_r_valid,
  output logic [DATA_W-1:0] ifu_r_data,
  output logic [RESP_W-1:0] ifu_r_resp,
  output logic              ifu_r_last,

  output logic              lsu_r_valid,
  output logic [DATA_W-1:0] lsu_r_data,
  output logic [RESP_W-1:0] lsu_r_resp,
  output logic              lsu_r_last,

  output logic              cpu_ar_valid,
  output logic [ID_W-1:0]   cpu_id,
  output logic [ADDR_W-1:0] cpu_addr,
  output logic [LEN_W-1:0]  cpu_len,
  output logic [SIZE_W-1:0] cpu_size,
  input  logic              cpu_ar_ready,

  input  logic              cpu_r_valid,
  input  logic [DATA_W-1:0] cpu_r_data,
  input  logic [RESP_W-1:0] cpu_r_resp,
  input  logic              cpu_r_last,

  output logic              arb_err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [LEN_W-1:0]  len_q,   len_d;
  logic [SIZE_W-1:0] size_q,  size_d;
  logic              port_q,  port_d;
  logic [LEN_W-1:0]  cnt_q,   cnt_d;
  logic              err_q,   err_d;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              accept;
  logic              beat;

  assign req    = {lsu_ar_valid, ifu_ar_valid};
  // Requests are only considered in IDLE and never while reset is asserted,
  // so nothing is granted (and no ready is shown) during reset.
  assign accept = (state_q == ST_IDLE) && !reset && (gnt != 2'b00);

  ysyx_22041071_rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .req_i (req),
    .upd_i (accept),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    port_d       = port_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    ifu_ar_ready = 1'b0;
    lsu_ar_ready = 1'b0;
    beat         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ifu_ar_ready = gnt[0];
          lsu_ar_ready = gnt[1];
          port_d       = gnt[1];
          addr_d       = gnt[1] ? lsu_addr : ifu_addr;
          len_d        = gnt[1] ? lsu_len  : ifu_len;
          size_d       = gnt[1] ? lsu_size : ifu_size;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cpu_ar_ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cpu_r_valid && !reset) begin
          beat  = 1'b1;
          cnt_d = cnt_q + 8'd1;
          // cnt_q is the index of this beat; the last flag must land exactly
          // on index len, early or late both count as a protocol error.
          if (cpu_r_last != (cnt_q == len_q)) begin
            err_d = 1'b1;
          end
          if (cpu_r_last) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      port_q  <= PORT_IFU;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      port_q  <= port_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign cpu_ar_valid = (state_q == ST_ISSUE);
  assign cpu_id       = port_to_id(port_q);
  assign cpu_addr     = addr_q;
  assign cpu_len      = len_q;
  assign cpu_size     = size_q;
  assign arb_err      = err_q;

  // Response payload is zeroed on the idle port so both ports read quiet
  // whenever no beat is routed to them.
  assign ifu_r_valid = beat && (port_q == PORT_IFU);
  assign ifu_r_data  = ifu_r_valid ? cpu_r_data : '0;
  assign ifu_r_resp  = ifu_r_valid ? cpu_r_resp : '0;
  assign ifu_r_last  = ifu_r_valid && cpu_r_last;

  assign lsu_r_valid = beat && (port_q == PORT_LSU);
  assign lsu_r_data  = lsu_r_valid ? cpu_r_data : '0;
  assign lsu_r_resp  = lsu_r_valid ? cpu_r_resp : '0;
  assign lsu_r_last  = lsu_r_valid && cpu_r_last;

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_arb.sv
module tb_ysyx_22041071_axi_rd_arb;

  logic        clk;
  logic        reset;
  logic        ifu_ar_valid, ifu_ar_ready;
  logic [63:0] ifu_addr;
  logic [7:0]  ifu_len;
  logic [1:0]  ifu_size;
  logic        lsu_ar_valid, lsu_ar_ready;
  logic [63:0] lsu_addr;
  logic [7:0]  lsu_len;
  logic [1:0]  lsu_size;
  logic        ifu_r_valid, ifu_r_last;
  logic [63:0] ifu_r_data;
  logic [1:0]  ifu_r_resp;
  logic        lsu_r_valid, lsu_r_last;
  logic [63:0] lsu_r_data;
  logic [1:0]  lsu_r_resp;
  logic        cpu_ar_valid, cpu_ar_ready;
  logic [3:0]  cpu_id;
  logic [63:0] cpu_addr;
  logic [7:0]  cpu_len;
  logic [1:0]  cpu_size;
  logic        cpu_r_valid, cpu_r_last;
  logic [63:0] cpu_r_data;
  logic [1:0]  cpu_r_resp;
  logic        arb_err;

  int checks = 0;
  int errors = 0;

  ysyx_22041071_axi_rd_arb dut (
    .clk          (clk),
    .reset        (reset),
    .ifu_ar_valid (ifu_ar_valid),
    .ifu_ar_ready (ifu_ar_ready),
    .ifu_addr     (ifu_addr),
    .ifu_len      (ifu_len),
    .ifu_size     (ifu_size),
    .lsu_ar_valid (lsu_ar_valid),
    .lsu_ar_ready (lsu_ar_ready),
    .lsu_addr     (lsu_addr),
    .lsu_len      (lsu_len),
    .lsu_size     (lsu_size),
    .ifu_r_valid  (ifu_r_valid),
    .ifu_r_data   (ifu_r_data),
    .ifu_r_resp   (ifu_r_resp),
    .ifu_r_last   (ifu_r_last),
    .lsu_r_valid  (lsu_r_valid),
    .lsu_r_data   (lsu_r_data),
    .lsu_r_resp   (lsu_r_resp),
    .lsu_r_last   (lsu_r_last),
    .cpu_ar_valid (cpu_ar_valid),
    .cpu_id       (cpu_id),
    .cpu_addr     (cpu_addr),
    .cpu_len      (cpu_len),
    .cpu_size     (cpu_size),
    .cpu_ar_ready (cpu_ar_ready),
    .cpu_r_valid  (cpu_r_valid),
    .cpu_r_data   (cpu_r_data),
    .cpu_r_resp   (cpu_r_resp),
    .cpu_r_last   (cpu_r_last),
    .arb_err      (arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        port;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  size;
    logic [1:0]  resp;
    logic [63:0] data0;
    logic [3:0]  exp_id;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Starts at a negedge with the FSM idle; ends at a negedge with it idle.
  task automatic run_txn(input logic port, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] size, input logic [1:0] resp,
                         input logic [63:0] data0, input logic [3:0] exp_id);
    if (port) begin
      lsu_ar_valid = 1'b1; lsu_addr = addr; lsu_len = len; lsu_size = size;
    end else begin
      ifu_ar_valid = 1'b1; ifu_addr = addr; ifu_len = len; ifu_size = size;
    end
    #1;
    check("ar_ready_granted", port ? lsu_ar_ready : ifu_ar_ready, 1);
    check("ar_ready_other",   port ? ifu_ar_ready : lsu_ar_ready, 0);
    @(negedge clk);
    ifu_ar_valid = 1'b0;
    lsu_ar_valid = 1'b0;
    #1;
    check("cpu_ar_valid_T+1", cpu_ar_valid, 1);
    check("cpu_addr", cpu_addr, addr);
    check("cpu_len",  cpu_len,  len);
    check("cpu_size", cpu_size, size);
    check("cpu_id",   cpu_id,   exp_id);
    check("ar_ready_issue", {ifu_ar_ready, lsu_ar_ready}, 0);
    cpu_ar_ready = 1'b1;
    @(negedge clk);
    cpu_ar_ready = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      cpu_r_valid = 1'b1;
      cpu_r_data  = data0 + 64'(i);
      cpu_r_resp  = resp;
      cpu_r_last  = (i == int'(len));
      #1;
      check("r_valid_port",  port ? lsu_r_valid : ifu_r_valid, 1);
      check("r_valid_other", port ? ifu_r_valid : lsu_r_valid, 0);
      check("r_data", port ? lsu_r_data : ifu_r_data, data0 + 64'(i));
      check("r_resp", port ? lsu_r_resp : ifu_r_resp, resp);
      check("r_last", port ? lsu_r_last : ifu_r_last, (i == int'(len)));
      @(negedge clk);
    end
    cpu_r_valid = 1'b0;
    cpu_r_last  = 1'b0;
    cpu_r_resp  = 2'b00;
    #1;
    check("r_valid_after", {ifu_r_valid, lsu_r_valid}, 0);
    check("cpu_ar_valid_after", cpu_ar_valid, 0);
  endtask

  initial begin
    reset = 1'b1;
    ifu_ar_valid = 0; ifu_addr = 0; ifu_len = 0; ifu_size = 0;
    lsu_ar_valid = 0; lsu_addr = 0; lsu_len = 0; lsu_size = 0;
    cpu_ar_ready = 0; cpu_r_valid = 0; cpu_r_data = 0; cpu_r_resp = 0; cpu_r_last = 0;

    vecs[0] = '{1'b0, 64'h0000_0000_8000_0004, 8'd0, 2'b10, 2'b00, 64'h0000_0013_0000_0093, 4'd0};
    vecs[1] = '{1'b1, 64'h0000_0000_8000_1000, 8'd3, 2'b11, 2'b00, 64'hdead_beef_0000_0000, 4'd1};
    vecs[2] = '{1'b0, 64'h0000_0000_8000_0100, 8'd1, 2'b11, 2'b00, 64'h1111_2222_3333_4444, 4'd0};
    vecs[3] = '{1'b1, 64'h0000_0000_0000_00ff, 8'd0, 2'b00, 2'b10, 64'h0000_0000_0000_00a5, 4'd1};

    // Reset state, with a request and a stray beat present during reset.
    @(negedge clk);
    ifu_ar_valid = 1'b1;
    cpu_r_valid  = 1'b1;
    #1;
    check("rst_ifu_ar_ready", ifu_ar_ready, 0);
    check("rst_cpu_ar_valid", cpu_ar_valid, 0);
    check("rst_r_valid", {ifu_r_valid, lsu_r_valid}, 0);
    check("rst_cpu_addr", cpu_addr, 0);
    check("rst_cpu_id", cpu_id, 0);
    check("rst_arb_err", arb_err, 0);
    @(negedge clk);
    ifu_ar_valid = 1'b0;
    cpu_r_valid  = 1'b0;
    reset = 1'b0;
    #1;
    check("idle_stray_none", {ifu_ar_ready, lsu_ar_ready, cpu_ar_valid}, 0);

    // Table of single-requester transactions.
    for (int v = 0; v < 4; v++) begin
      run_txn(vecs[v].port, vecs[v].addr, vecs[v].len, vecs[v].size,
              vecs[v].resp, vecs[v].data0, vecs[v].exp_id);
    end
    check("arb_err_clean", arb_err, 0);

    // Tie after reset goes to ifu, then grants alternate while both held.
    do_reset();
    ifu_ar_valid = 1'b1; ifu_addr = 64'h8000_0000; ifu_len = 0; ifu_size = 2'b10;
    lsu_ar_valid = 1'b1; lsu_addr = 64'h8000_2000; lsu_len = 0; lsu_size = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("alt_ifu_ready", ifu_ar_ready, (k % 2 == 0));
      check("alt_lsu_ready", lsu_ar_ready, (k % 2 == 1));
      @(negedge clk);
      #1;
      check("alt_cpu_id", cpu_id, 64'(k % 2));
      check("alt_cpu_addr", cpu_addr, (k % 2 == 0) ? 64'h8000_0000 : 64'h8000_2000);
      cpu_ar_ready = 1'b1;
      @(negedge clk);
      cpu_ar_ready = 1'b0;
      cpu_r_valid = 1'b1; cpu_r_last = 1'b1; cpu_r_data = 64'(k);
      #1;
      check("alt_r_valid", {lsu_r_valid, ifu_r_valid}, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("alt_ready_leaving_wait", {ifu_ar_ready, lsu_ar_ready}, 0);
      @(negedge clk);
      cpu_r_valid = 1'b0; cpu_r_last = 1'b0;
    end
    ifu_ar_valid = 1'b0;
    lsu_ar_valid = 1'b0;
    @(negedge clk);

    // Early last: len 3 with last on the 2nd beat.
    lsu_ar_valid = 1'b1; lsu_addr = 64'h8000_3000; lsu_len = 8'd3; lsu_size = 2'b11;
    @(negedge clk);
    lsu_ar_valid = 1'b0;
    cpu_ar_ready = 1'b1;
    @(negedge clk);
    cpu_ar_ready = 1'b0;
    cpu_r_valid = 1'b1; cpu_r_last = 1'b0; cpu_r_data = 64'h10;
    #1;
    check("early_beat0", lsu_r_valid, 1);
    @(negedge clk);
    cpu_r_last = 1'b1; cpu_r_data = 64'h11;
    #1;
    check("early_beat1_last", lsu_r_last, 1);
    @(negedge clk);
    cpu_r_valid = 1'b0; cpu_r_last = 1'b0;
    #1;
    check("early_arb_err", arb_err, 1);
    run_txn(1'b0, 64'h8000_0040, 8'd0, 2'b10, 2'b00, 64'h55, 4'd0);
    check("arb_err_sticky", arb_err, 1);
    do_reset();
    #1;
    check("arb_err_cleared", arb_err, 0);

    // Reset during WAIT followed by stray beats.
    @(negedge clk);
    lsu_ar_valid = 1'b1; lsu_addr = 64'h8000_4000; lsu_len = 8'd3; lsu_size = 2'b11;
    @(negedge clk);
    lsu_ar_valid = 1'b0;
    cpu_ar_ready = 1'b1;
    @(negedge clk);
    cpu_ar_ready = 1'b0;
    cpu_r_valid = 1'b1; cpu_r_data = 64'h20;
    #1;
    check("midrst_beat0", lsu_r_valid, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_in_reset", {ifu_r_valid, lsu_r_valid}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      #1;
      check("midrst_stray_r_valid", {ifu_r_valid, lsu_r_valid}, 0);
      check("midrst_outputs", {cpu_ar_valid, ifu_ar_ready, lsu_ar_ready, arb_err}, 0);
      check("midrst_cpu_addr", cpu_addr, 0);
      @(negedge clk);
    end
    cpu_r_valid = 1'b0;
    run_txn(1'b1, 64'h8000_5000, 8'd1, 2'b11, 2'b00, 64'h300, 4'd1);

    // Master stalls cpu_ar_ready for 5 cycles; lsu waits, stray beats ignored.
    ifu_ar_valid = 1'b1; ifu_addr = 64'h8000_6008; ifu_len = 8'd0; ifu_size = 2'b10;
    @(negedge clk);
    ifu_ar_valid = 1'b0;
    lsu_ar_valid = 1'b1; lsu_addr = 64'h8000_7000; lsu_len = 8'd0; lsu_size = 2'b01;
    cpu_r_valid = 1'b1; cpu_r_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_cpu_ar_valid", cpu_ar_valid, 1);
      check("stall_cpu_addr", cpu_addr, 64'h8000_6008);
      check("stall_ar_ready", {ifu_ar_ready, lsu_ar_ready}, 0);
      check("stall_stray", {ifu_r_valid, lsu_r_valid}, 0);
      @(negedge clk);
    end
    cpu_r_valid = 1'b0; cpu_r_last = 1'b0;
    cpu_ar_ready = 1'b1;
    @(negedge clk);
    cpu_ar_ready = 1'b0;
    cpu_r_valid = 1'b1; cpu_r_last = 1'b1; cpu_r_data = 64'h77;
    #1;
    check("stall_ifu_beat", {lsu_r_valid, ifu_r_valid}, 2'b01);
    @(negedge clk);
    cpu_r_valid = 1'b0; cpu_r_last = 1'b0;
    #1;
    check("stall_lsu_granted", lsu_ar_ready, 1);
    @(negedge clk);
    lsu_ar_valid = 1'b0;
    #1;
    check("stall_lsu_id", cpu_id, 1);
    check("stall_lsu_addr", cpu_addr, 64'h8000_7000);
    cpu_ar_ready = 1'b1;
    @(negedge clk);
    cpu_ar_ready = 1'b0;
    cpu_r_valid = 1'b1; cpu_r_last = 1'b1;
    #1;
    check("stall_lsu_beat", {lsu_r_valid, ifu_r_valid}, 2'b10);
    @(negedge clk);
    cpu_r_valid = 1'b0; cpu_r_last = 1'b0;
    #1;
    check("final_arb_err", arb_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22041071_axi_rd_arb.md
YSYX_22041071_AXI_RD_ARB -- requirements
Module: ysyx_22041071_axi_rd_arb

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ifu_ar_valid / ifu_ar_ready  in / out  1 / 1  fetch read request handshake (port 0).
REQ-005 ifu_addr, ifu_len, ifu_size  in  64, 8, 2  fetch address, beats-1, size code (00=1B .. 11=8B).
REQ-006 lsu_ar_valid / lsu_ar_ready, lsu_addr, lsu_len, lsu_size  same widths  load read request (port 1).
REQ-007 ifu_r_valid, ifu_r_data, ifu_r_resp, ifu_r_last  out  1, 64, 2, 1  fetch response beat, one-cycle pulse.
REQ-008 lsu_r_valid, lsu_r_data, lsu_r_resp, lsu_r_last  out  1, 64, 2, 1  load response beat, one-cycle pulse.
REQ-009 cpu_ar_valid, cpu_id, cpu_addr, cpu_len, cpu_size  out  1, 4, 64, 8, 2  request to the AXI read master.
REQ-010 cpu_ar_ready  in  1  read master accepts the request.
REQ-011 cpu_r_valid, cpu_r_data, cpu_r_resp, cpu_r_last  in  1, 64, 2, 1  read master beat; cpu_r_valid is one pulse per beat.
REQ-012 arb_err  out  1  sticky beat-count protocol error.

Function
REQ-013 States SHALL be IDLE, ISSUE, WAIT.
- IDLE: grant one valid requester, hold its ar_ready high combinationally in that cycle, latch addr/len/size/port, go to ISSUE; no request -> stay IDLE.
- ISSUE: cpu_ar_valid=1 from latched registers; on cpu_ar_ready -> WAIT.
- WAIT: route beats; on beat with cpu_r_last=1 -> IDLE.
REQ-014 Both ar_ready outputs SHALL be 0 in ISSUE and WAIT; exactly one port is granted per transaction.
REQ-015 Arbitration SHALL be two-way round-robin: one requester -> it wins; both -> the port not granted last wins; last-grant register resets to port 1, so the first tie after reset goes to ifu.
REQ-016 Latency: request accepted in cycle T -> cpu_ar_valid high in T+1; cpu_addr/len/size/id stable while cpu_ar_valid is high.
REQ-017 cpu_id SHALL be 4'd0 for ifu and 4'd1 for lsu.
REQ-018 Each cpu_r_valid beat in WAIT SHALL appear in the same cycle (combinational, no buffering) on the latched port's r_valid/data/resp/last; the other port's r_valid stays 0.
REQ-019 cpu_r_valid outside WAIT SHALL be ignored and not forwarded.
REQ-020 An 8-bit beat counter SHALL clear on entry to WAIT and increment per beat.
REQ-021 arb_err SHALL set if cpu_r_last=1 with count != latched len, or count == len on a beat with cpu_r_last=0; it clears only on reset.
REQ-022 Non-zero cpu_r_resp SHALL be passed through unchanged; it does not alter state transitions.
REQ-023 A requester raising valid in the same cycle the FSM leaves WAIT SHALL be seen only in the following IDLE cycle.

Reset
REQ-024 On reset: state=IDLE, all request registers 0, last-grant=1, beat counter 0, arb_err=0, every output 0.
REQ-025 Reset mid-transaction SHALL abandon it with no further response pulses; cpu_ar_valid drops in the next cycle.

Structure
REQ-026 State encodings, port IDs (0/1), and the 64/8/2/4 widths SHALL be shared constants in define.v.
REQ-027 Grant logic SHALL be one sub-module, ysyx_22041071_rr_arb2: 2 req in, 2 one-hot grant out, last-grant register inside.

Verification
REQ-028 ifu only, addr 0x8000_0004, len 0 -> ifu_ar_ready in T, cpu_ar_valid in T+1 with addr 0x8000_0004, id 0; one beat with last -> single ifu_r_valid pulse; lsu_r_valid stays 0.
REQ-029 ifu and lsu valid together after reset -> ifu served first, then lsu; both held valid -> grants alternate 0,1,0,1.
REQ-030 lsu len 3, four beats with last on the 4th -> four lsu_r_valid pulses, lsu_r_last on the 4th only, arb_err stays 0.
REQ-031 len 3 but last on the 2nd beat -> arb_err=1 and FSM returns to IDLE; arb_err stays 1 until reset.
REQ-032 reset asserted during WAIT, then 2 stray beats -> no r_valid pulses, all outputs 0, next request served normally.
REQ-033 cpu_ar_ready held low 5 cycles -> cpu_ar_valid and payload held stable for 5 cycles, both ar_ready stay 0.
